verify_block: RTL and testbench



---
 rtl/verify_block_pkg.sv | 31 +++
 rtl/pearson_hash64.sv | 43 ++++
 rtl/verify_block.sv | 155 +++++++++++++++
 tb/tb_verify_block.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verify_block_pkg.sv
// Shared definitions for the block verifier: FSM encoding, reject codes and
// the block message field layout used by both the miner and the verifier.
package verify_block_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_HASH   = 3'd2,
      S_CHECK  = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   localparam logic [2:0] RC_OK       = 3'd0;
   localparam logic [2:0] RC_BAD_PREV = 3'd1;
   localparam logic [2:0] RC_BAD_SIG  = 3'd2;
   localparam logic [2:0] RC_BAD_HASH = 3'd3;
   localparam logic [2:0] RC_BAD_DIFF = 3'd4;
   localparam logic [2:0] RC_NO_FUNDS = 3'd5;
   localparam logic [2:0] RC_TIMEOUT  = 3'd6;

   localparam int PREV_MSB = 63;
   localparam int PREV_LSB = 56;
   localparam int AMT_MSB  = 55;
   localparam int AMT_LSB  = 48;
   localparam int SIG_MSB  = 47;
   localparam int SIG_LSB  = 40;
   localparam int DIR_BIT  = 39;

   localparam int TABLE_BYTES = 36;

endpackage

// File: rtl/pearson_hash64.sv
// Pearson hash of a 64-bit message, one byte per cycle, MSB byte first.
// The 288-bit table is 36 byte entries indexed by (hash ^ byte) mod 36.
module pearson_hash64
   import verify_block_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         enable,
   input  logic [63:0]  message,
   input  logic [287:0] random_table,
   output logic [7:0]   hash,
   output logic         finished
);

   logic [2:0] idx;
   logic [7:0] msg_byte;
   logic [7:0] mix;
   logic [5:0] tidx;
   logic [7:0] tbl [TABLE_BYTES];

   always_comb begin
      for (int k = 0; k < TABLE_BYTES; k++) begin
         tbl[k] = random_table[8*k +: 8];
      end
      msg_byte = message[{3'd7 - idx, 3'b000} +: 8];
      mix      = hash ^ msg_byte;
      tidx     = 6'(mix % 8'(TABLE_BYTES));
   end

   // finished is sticky until the next reset so the consumer cannot miss it
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hash     <= 8'd0;
         idx      <= 3'd0;
         finished <= 1'b0;
      end else if (enable && !finished) begin
         hash <= tbl[tidx];
         idx  <= idx + 3'd1;
         if (idx == 3'd7) finished <= 1'b1;
      end
   end

endmodule

// File: rtl/verify_block.sv
// Verifies a mined block (linkage, signature, hash, difficulty, funds) and
// commits accepted transfers to the two-player ledger; last_hash is the chain tip.
module verify_block
   import verify_block_pkg::*;
#(
   parameter logic [7:0] INIT_BALANCE    = 8'd100,
   parameter int         DIFFICULTY_BITS = 4,
   parameter int         RESET_HOLD      = 2,
   parameter int         HASH_TIMEOUT    = 255
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         start,
   input  logic [63:0]  message,
   input  logic [7:0]   claimed_hash,
   input  logic [287:0] random_table,
   input  logic [7:0]   p1_sig,
   input  logic [7:0]   p2_sig,
   output logic         busy,
   output logic         done,
   output logic         accepted,
   output logic [2:0]   reject_code,
   output logic [7:0]   p1_balance,
   output logic [7:0]   p2_balance,
   output logic [7:0]   last_hash,
   output state_t       state_dbg
);

   localparam int CNT_MAX = (RESET_HOLD > HASH_TIMEOUT) ? RESET_HOLD : HASH_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t          state;
   logic [63:0]     msg_q;
   logic [7:0]      claimed_q;
   logic [7:0]      computed_q;
   logic            timeout_q;
   logic [CW-1:0]   cnt;
   logic            core_rstn;
   logic [7:0]      hash_value;
   logic            hash_finished;

   logic [7:0] prev_f, amt_f, sig_f;
   logic       dir_f;
   logic [7:0] payer_bal, payee_bal, payer_sig, payer_new, payee_new;
   logic [8:0] payee_sum;
   logic [2:0] verdict;

   assign state_dbg = state;
   assign prev_f    = msg_q[PREV_MSB:PREV_LSB];
   assign amt_f     = msg_q[AMT_MSB:AMT_LSB];
   assign sig_f     = msg_q[SIG_MSB:SIG_LSB];
   assign dir_f     = msg_q[DIR_BIT];

   pearson_hash64 u_hash (
      .clock        (clock),
      .reset_n      (core_rstn),
      .enable       (1'b1),
      .message      (msg_q),
      .random_table (random_table),
      .hash         (hash_value),
      .finished     (hash_finished)
   );

   // First failing check wins; direction 1 means P2 is the payer.
   always_comb begin
      payer_bal = dir_f ? p2_balance : p1_balance;
      payee_bal = dir_f ? p1_balance : p2_balance;
      payer_sig = dir_f ? p2_sig : p1_sig;
      payee_sum = {1'b0, payee_bal} + {1'b0, amt_f};
      payee_new = payee_sum[8] ? 8'hFF : payee_sum[7:0];
      payer_new = payer_bal - amt_f;
      verdict   = RC_OK;
      if (timeout_q)                                          verdict = RC_TIMEOUT;
      else if (prev_f != last_hash)                           verdict = RC_BAD_PREV;
      else if (sig_f != payer_sig)                            verdict = RC_BAD_SIG;
      else if (computed_q != claimed_q)                       verdict = RC_BAD_HASH;
      else if ((computed_q >> (8 - DIFFICULTY_BITS)) != 8'd0) verdict = RC_BAD_DIFF;
      else if (payer_bal < amt_f)                             verdict = RC_NO_FUNDS;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         accepted    <= 1'b0;
         reject_code <= RC_OK;
         p1_balance  <= INIT_BALANCE;
         p2_balance  <= INIT_BALANCE;
         last_hash   <= 8'd0;
         msg_q       <= 64'd0;
         claimed_q   <= 8'd0;
         computed_q  <= 8'd0;
         timeout_q   <= 1'b0;
         cnt         <= '0;
         core_rstn   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  msg_q     <= message;
                  claimed_q <= claimed_hash;
                  timeout_q <= 1'b0;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (cnt == CW'(RESET_HOLD - 1)) begin
                  cnt       <= '0;
                  core_rstn <= 1'b1;
                  state     <= S_HASH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HASH: begin
               if (hash_finished) begin
                  computed_q <= hash_value;
                  core_rstn  <= 1'b0;
                  state      <= S_CHECK;
               end else if (cnt == CW'(HASH_TIMEOUT - 1)) begin
                  timeout_q <= 1'b1;
                  core_rstn <= 1'b0;
                  state     <= S_CHECK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_CHECK: begin
               done        <= 1'b1;
               busy        <= 1'b0;
               accepted    <= (verdict == RC_OK);
               reject_code <= verdict;
               if (verdict == RC_OK) begin
                  last_hash <= computed_q;
                  if (dir_f) begin
                     p2_balance <= payer_new;
                     p1_balance <= payee_new;
                  end else begin
                     p1_balance <= payer_new;
                     p2_balance <= payee_new;
                  end
               end
               state <= S_COMMIT;
            end
            S_COMMIT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_verify_block.sv
// Bench for verify_block: directed vector table, multi-cycle corner sequences
// and randomized blocks checked against a rule-level ledger model.
module tb_verify_block;
   import verify_block_pkg::*;

   localparam int         RH     = 2;
   localparam int         HT     = 255;
   localparam int         DIFF   = 4;
   localparam logic [7:0] INIT   = 8'd100;
   localparam logic [7:0] INIT_S = 8'd200;
   localparam logic [7:0] P1_SIG = 8'hA5;
   localparam logic [7:0] P2_SIG = 8'h3C;

   logic         clock, resetn, start, start_s;
   logic [63:0]  message;
   logic [7:0]   claimed_hash;
   logic [287:0] random_table;
   logic [7:0]   p1_sig, p2_sig;
   logic         busy, done, accepted;
   logic [2:0]   reject_code;
   logic [7:0]   p1_balance, p2_balance, last_hash;
   state_t       state_dbg;
   logic         busy_s, done_s, accepted_s;
   logic [2:0]   reject_code_s;
   logic [7:0]   p1_balance_s, p2_balance_s, last_hash_s;
   state_t       state_dbg_s;

   verify_block #(.INIT_BALANCE(INIT), .DIFFICULTY_BITS(DIFF), .RESET_HOLD(RH), .HASH_TIMEOUT(HT)) dut (
      .clock(clock), .resetn(resetn), .start(start), .message(message),
      .claimed_hash(claimed_hash), .random_table(random_table), .p1_sig(p1_sig), .p2_sig(p2_sig),
      .busy(busy), .done(done), .accepted(accepted), .reject_code(reject_code),
      .p1_balance(p1_balance), .p2_balance(p2_balance), .last_hash(last_hash), .state_dbg(state_dbg)
   );

   verify_block #(.INIT_BALANCE(INIT_S), .DIFFICULTY_BITS(DIFF), .RESET_HOLD(RH), .HASH_TIMEOUT(HT)) dut_sat (
      .clock(clock), .resetn(resetn), .start(start_s), .message(message),
      .claimed_hash(claimed_hash), .random_table(random_table), .p1_sig(p1_sig), .p2_sig(p2_sig),
      .busy(busy_s), .done(done_s), .accepted(accepted_s), .reject_code(reject_code_s),
      .p1_balance(p1_balance_s), .p2_balance(p2_balance_s), .last_hash(last_hash_s), .state_dbg(state_dbg_s)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0]  tbl [36];
   logic [7:0]  p1_m, p2_m, last_m;
   logic [26:0] exp_q [$];

   typedef struct {
      logic       prev_ok;
      logic       sig_ok;
      logic [7:0] hash_delta;
      logic       dir;
      logic [7:0] amt;
      logic       diff_ok;
      logic [2:0] exp_code;
      logic [7:0] exp_p1;
      logic [7:0] exp_p2;
   } vec_t;
   vec_t vecs [10];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [7:0] pearson(input logic [63:0] m);
      logic [7:0] h, b;
      h = 8'd0;
      for (int i = 0; i < 8; i++) begin
         b = m[63-8*i -: 8];
         h = tbl[int'(h ^ b) % 36];
      end
      return h;
   endfunction

   // Searches proof-of-work values until the hash meets (or misses) the difficulty.
   task automatic build_block(input logic [7:0] prev, input logic [7:0] amt, input logic [7:0] sig,
                              input logic dir, input logic diff_ok, output logic [63:0] msg);
      logic [63:0] r;
      for (int t = 0; t < 4000; t++) begin
         r   = {$urandom(), $urandom()};
         msg = {prev, amt, sig, dir, r[38:0]};
         if ((int'(pearson(msg)) < (256 >> DIFF)) == diff_ok) break;
      end
   endtask

   task automatic model_eval(input logic [63:0] msg, input logic [7:0] claimed, output logic [2:0] code,
                             output logic [7:0] np1, output logic [7:0] np2, output logic [7:0] nlast);
      int payer, payee, amt;
      logic [7:0] comp;
      logic dir;
      comp  = pearson(msg);
      dir   = msg[39];
      amt   = int'(msg[55:48]);
      payer = dir ? int'(p2_m) : int'(p1_m);
      payee = dir ? int'(p1_m) : int'(p2_m);
      np1 = p1_m; np2 = p2_m; nlast = last_m;
      if (msg[63:56] != last_m)                  code = RC_BAD_PREV;
      else if (msg[47:40] != (dir ? P2_SIG : P1_SIG)) code = RC_BAD_SIG;
      else if (claimed != comp)                  code = RC_BAD_HASH;
      else if (int'(comp) >= (256 >> DIFF))      code = RC_BAD_DIFF;
      else if (payer < amt)                      code = RC_NO_FUNDS;
      else begin
         code  = RC_OK;
         payer = payer - amt;
         payee = (payee + amt > 255) ? 255 : payee + amt;
         nlast = comp;
         if (dir) begin np2 = 8'(payer); np1 = 8'(payee); end
         else     begin np1 = 8'(payer); np2 = 8'(payee); end
      end
   endtask

   // Drives one block into the main DUT and scores the verdict against exp_q.
   task automatic run_block(input logic [63:0] msg, input logic [7:0] claimed, input logic [2:0] e_code,
                            input logic [7:0] e_p1, input logic [7:0] e_p2, input logic [7:0] e_last,
                            input int e_lat, input string name);
      logic [26:0] e;
      int c;
      exp_q.push_back({e_code, e_p1, e_p2, e_last});
      message = msg; claimed_hash = claimed; start = 1'b1;
      step();
      start = 1'b0;
      check({name, "_busy_rise"}, 32'(busy), 32'd1);
      c = 1;
      while (!done && c < 600) begin
         step();
         c++;
      end
      e = exp_q.pop_front();
      check({name, "_latency"},  32'(c),            32'(e_lat));
      check({name, "_accepted"}, 32'(accepted),     32'(e[26:24] == RC_OK));
      check({name, "_code"},     32'(reject_code),  32'(e[26:24]));
      check({name, "_p1"},       32'(p1_balance),   32'(e[23:16]));
      check({name, "_p2"},       32'(p2_balance),   32'(e[15:8]));
      check({name, "_last"},     32'(last_hash),    32'(e[7:0]));
      check({name, "_busy_fall"}, 32'(busy),        32'd0);
      step();
   endtask

   initial begin
      logic [63:0] msg;
      logic [7:0]  comp, prev, sig, e_last, e_p1, e_p2;
      logic [2:0]  e_code;
      logic        dir;
      int          n_done, fault;
      logic [7:0]  got_last;

      vecs[0] = '{1'b1, 1'b1, 8'd0, 1'b0, 8'd30,  1'b1, RC_OK,       8'd70,  8'd130};
      vecs[1] = '{1'b0, 1'b1, 8'd0, 1'b0, 8'd30,  1'b1, RC_BAD_PREV, 8'd70,  8'd130};
      vecs[2] = '{1'b1, 1'b0, 8'd1, 1'b0, 8'd10,  1'b1, RC_BAD_SIG,  8'd70,  8'd130};
      vecs[3] = '{1'b1, 1'b1, 8'd1, 1'b0, 8'd10,  1'b1, RC_BAD_HASH, 8'd70,  8'd130};
      vecs[4] = '{1'b1, 1'b1, 8'd0, 1'b0, 8'd10,  1'b0, RC_BAD_DIFF, 8'd70,  8'd130};
      vecs[5] = '{1'b1, 1'b1, 8'd0, 1'b1, 8'd200, 1'b1, RC_NO_FUNDS, 8'd70,  8'd130};
      vecs[6] = '{1'b1, 1'b1, 8'd0, 1'b1, 8'd0,   1'b1, RC_OK,       8'd70,  8'd130};
      vecs[7] = '{1'b1, 1'b1, 8'd0, 1'b1, 8'd130, 1'b1, RC_OK,       8'd200, 8'd0};
      vecs[8] = '{1'b1, 1'b1, 8'd0, 1'b0, 8'd201, 1'b1, RC_NO_FUNDS, 8'd200, 8'd0};
      vecs[9] = '{1'b1, 1'b1, 8'd0, 1'b0, 8'd200, 1'b1, RC_OK,       8'd0,   8'd200};

      for (int k = 0; k < 36; k++) begin
         tbl[k] = 8'($urandom());
         random_table[8*k +: 8] = tbl[k];
      end
      p1_sig = P1_SIG; p2_sig = P2_SIG;
      start = 1'b0; start_s = 1'b0; message = 64'd0; claimed_hash = 8'd0;
      resetn = 1'b0;
      repeat (3) step();
      check("rst_busy",  32'(busy),        32'd0);
      check("rst_done",  32'(done),        32'd0);
      check("rst_acc",   32'(accepted),    32'd0);
      check("rst_code",  32'(reject_code), 32'd0);
      check("rst_p1",    32'(p1_balance),  32'(INIT));
      check("rst_p2",    32'(p2_balance),  32'(INIT));
      check("rst_last",  32'(last_hash),   32'd0);
      check("rst_state", 32'(state_dbg),   32'(S_IDLE));
      check("rst_sat_p1", 32'(p1_balance_s), 32'(INIT_S));
      resetn = 1'b1;
      step();
      p1_m = INIT; p2_m = INIT; last_m = 8'd0;

      // directed vector table
      for (int v = 0; v < 10; v++) begin
         dir  = vecs[v].dir;
         prev = vecs[v].prev_ok ? last_m : (last_m ^ 8'hFF);
         sig  = vecs[v].sig_ok ? (dir ? P2_SIG : P1_SIG) : 8'h00;
         build_block(prev, vecs[v].amt, sig, dir, vecs[v].diff_ok, msg);
         comp   = pearson(msg);
         e_last = (vecs[v].exp_code == RC_OK) ? comp : last_m;
         run_block(msg, comp + vecs[v].hash_delta, vecs[v].exp_code, vecs[v].exp_p1, vecs[v].exp_p2,
                   e_last, RH + 11, $sformatf("vec%0d", v));
         p1_m = vecs[v].exp_p1; p2_m = vecs[v].exp_p2; last_m = e_last;
      end

      // start pulse while hashing must be dropped
      build_block(last_m, 8'd0, P1_SIG, 1'b0, 1'b1, msg);
      comp = pearson(msg);
      message = msg; claimed_hash = comp; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      message = ~msg; start = 1'b1;
      step();
      start = 1'b0; message = msg;
      n_done = 0; got_last = 8'd0;
      for (int c = 0; c < 40; c++) begin
         if (done) begin n_done++; got_last = last_hash; end
         step();
      end
      check("drop_done_count", 32'(n_done),   32'd1);
      check("drop_last",       32'(got_last), 32'(comp));
      check("drop_idle_busy",  32'(busy),     32'd0);
      last_m = comp;

      // hash core that never finishes
      build_block(last_m, 8'd0, P1_SIG, 1'b0, 1'b1, msg);
      comp = pearson(msg);
      force dut.hash_finished = 1'b0;
      run_block(msg, comp, RC_TIMEOUT, p1_m, p2_m, last_m, RH + HT + 2, "timeout");
      release dut.hash_finished;
      step();

      // reset while hashing
      build_block(last_m, 8'd0, P1_SIG, 1'b0, 1'b1, msg);
      comp = pearson(msg);
      message = msg; claimed_hash = comp; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      check("midrst_state_hash", 32'(state_dbg), 32'(S_HASH));
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check("midrst_busy", 32'(busy),       32'd0);
      check("midrst_p1",   32'(p1_balance), 32'(INIT));
      check("midrst_p2",   32'(p2_balance), 32'(INIT));
      check("midrst_last", 32'(last_hash),  32'd0);
      n_done = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) n_done++;
         step();
      end
      check("midrst_no_done", 32'(n_done), 32'd0);
      p1_m = INIT; p2_m = INIT; last_m = 8'd0;

      // randomized blocks against the ledger model
      for (int r = 0; r < 24; r++) begin
         dir   = 1'($urandom_range(0, 1));
         fault = $urandom_range(0, 5);
         prev  = (fault == 1) ? (last_m ^ 8'($urandom_range(1, 255))) : last_m;
         sig   = (dir ? P2_SIG : P1_SIG) ^ ((fault == 2) ? 8'h81 : 8'h00);
         build_block(prev, 8'($urandom_range(0, 150)), sig, dir, fault != 4, msg);
         comp = pearson(msg);
         if (fault == 3) comp = comp + 8'($urandom_range(1, 255));
         model_eval(msg, comp, e_code, e_p1, e_p2, e_last);
         run_block(msg, comp, e_code, e_p1, e_p2, e_last, RH + 11, $sformatf("rnd%0d", r));
         p1_m = e_p1; p2_m = e_p2; last_m = e_last;
      end

      // payee saturation on the instance that starts at 200/200
      build_block(last_hash_s, 8'd100, P2_SIG, 1'b1, 1'b1, msg);
      comp = pearson(msg);
      message = msg; claimed_hash = comp; start_s = 1'b1;
      step();
      start_s = 1'b0;
      for (int c = 0; c < 600 && !done_s; c++) step();
      check("sat_done", 32'(done_s),       32'd1);
      check("sat_acc",  32'(accepted_s),   32'd1);
      check("sat_p1",   32'(p1_balance_s), 32'd255);
      check("sat_p2",   32'(p2_balance_s), 32'd100);
      check("sat_last", 32'(last_hash_s),  32'(comp));
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
